// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - HI/LO multiply/divide sequencer for the MIPS execute stage
// Defining MULDIV_FAST_MULT_EN selects a single-cycle multiplier instead of 32-step shift-add.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        read_hilo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        stall_o
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      r_state, w_next_state;
  logic        r_done, w_done_next;
  logic [31:0] r_hi, r_lo;
  // r_acc: partial remainder or product high half; r_shf: dividend/quotient or multiplier/product low half
  logic [31:0] r_acc, r_shf, r_opb;
  logic [4:0]  r_cnt;
  logic        r_neg_q, r_neg_r, r_is_div, r_div0;
  logic        w_accept, w_signed, w_last, w_dfits;
  logic [31:0] w_mag_a, w_mag_b, w_ddiff;
  logic [32:0] w_dshift;
`ifdef MULDIV_FAST_MULT_EN
  logic        r_signed;
  logic [63:0] w_ea, w_eb, w_fprod;
`else
  logic [32:0] w_msum;
`endif

  assign w_accept = start_i & (r_state == S_IDLE);
  assign w_signed = (op_i == 3'd0) | (op_i == 3'd2);
  assign w_mag_a  = (w_signed & rs_i[31]) ? -rs_i : rs_i;
  assign w_mag_b  = (w_signed & rt_i[31]) ? -rt_i : rt_i;
  assign w_last   = (r_cnt == 5'd31);

  assign w_dshift = {r_acc, r_shf[31]};
  assign w_dfits  = (w_dshift >= {1'b0, r_opb});
  assign w_ddiff  = w_dshift[31:0] - r_opb;

`ifdef MULDIV_FAST_MULT_EN
  assign w_ea = r_signed ? {{32{r_shf[31]}}, r_shf} : {32'd0, r_shf};
  assign w_eb = r_signed ? {{32{r_opb[31]}}, r_opb} : {32'd0, r_opb};
  always_comb begin
    if (r_signed) w_fprod = $signed(w_ea) * $signed(w_eb);
    else          w_fprod = w_ea * w_eb;
  end
`else
  assign w_msum = {1'b0, r_acc} + (r_shf[0] ? {1'b0, r_opb} : 33'd0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (op_i)
            3'd0, 3'd1: w_next_state = S_MUL;
            3'd2, 3'd3: w_next_state = S_DIV;
            3'd4, 3'd5: w_done_next  = 1'b1;
            default:    w_next_state = S_IDLE;
          endcase
        end
      end
      S_MUL: begin
`ifdef MULDIV_FAST_MULT_EN
        w_next_state = S_IDLE;
        w_done_next  = 1'b1;
`else
        if (w_last) w_next_state = S_FIX;
`endif
      end
      S_DIV: if (w_last) w_next_state = S_FIX;
      S_FIX: begin
        w_next_state = S_IDLE;
        w_done_next  = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_acc    <= 32'd0;
      r_shf    <= 32'd0;
      r_opb    <= 32'd0;
      r_cnt    <= 5'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
`ifdef MULDIV_FAST_MULT_EN
      r_signed <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (op_i)
              3'd4: r_hi <= rs_i;
              3'd5: r_lo <= rs_i;
              3'd0, 3'd1, 3'd2, 3'd3: begin
                r_cnt    <= 5'd0;
                r_acc    <= 32'd0;
                r_shf    <= w_mag_a;
                r_opb    <= w_mag_b;
                r_neg_q  <= w_signed & (rs_i[31] ^ rt_i[31]);
                r_neg_r  <= w_signed & rs_i[31];
                r_is_div <= op_i[1];
                r_div0   <= (rt_i == 32'd0);
`ifdef MULDIV_FAST_MULT_EN
                r_signed <= ~op_i[0];
                if (!op_i[1]) begin
                  r_shf <= rs_i;
                  r_opb <= rt_i;
                end
`endif
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
`ifdef MULDIV_FAST_MULT_EN
          {r_hi, r_lo} <= w_fprod;
`else
          {r_acc, r_shf} <= {w_msum, r_shf[31:1]};
          r_cnt          <= r_cnt + 5'd1;
`endif
        end
        S_DIV: begin
          r_acc <= w_dfits ? w_ddiff : w_dshift[31:0];
          r_shf <= {r_shf[30:0], w_dfits};
          r_cnt <= r_cnt + 5'd1;
        end
        S_FIX: begin
          // With a zero divisor every step "fits", so r_acc ends as |rs| and the sign fix restores raw rs.
          if (r_is_div) begin
            r_lo <= r_div0 ? 32'hFFFF_FFFF : (r_neg_q ? -r_shf : r_shf);
            r_hi <= r_neg_r ? -r_acc : r_acc;
          end else begin
            {r_hi, r_lo} <= r_neg_q ? -{r_acc, r_shf} : {r_acc, r_shf};
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_o    = r_hi;
  assign lo_o    = r_lo;
  assign busy_o  = (r_state != S_IDLE);
  assign done_o  = r_done;
  assign stall_o = busy_o & (start_i | read_hilo_i);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] rs_i = 32'd0;
  logic [31:0] rt_i = 32'd0;
  logic        read_hilo_i = 1'b0;
  logic [31:0] hi_o, lo_o;
  logic        busy_o, done_o, stall_o;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i), .rs_i(rs_i), .rt_i(rt_i),
    .read_hilo_i(read_hilo_i), .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .done_o(done_o),
    .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] val;
    int          t0;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          e_done_cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint a, b, q, r;
    logic [63:0] res;
    a = longint'($signed(rs));
    b = longint'($signed(rt));
    res = {m_hi, m_lo};
    case (op)
      3'd0: begin q = a * b; res = q; end
      3'd1: res = {32'd0, rs} * {32'd0, rt};
      3'd2: begin
        if (rt == 32'd0) res = {rs, 32'hFFFF_FFFF};
        else begin q = a / b; r = a % b; res = {r[31:0], q[31:0]}; end
      end
      3'd3: begin
        if (rt == 32'd0) res = {rs, 32'hFFFF_FFFF};
        else res = {rs % rt, rs / rt};
      end
      3'd4: res = {rs, m_lo};
      3'd5: res = {m_hi, rs};
      default: ;
    endcase
    return res;
  endfunction

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt, input logic rd);
    bit   acc;
    bit   eb;
    exp_t e;
    acc = 0;
    start_i = 1'b1; op_i = op; rs_i = rs; rt_i = rt; read_hilo_i = rd;
    for (int i = 0; i < 100 && !acc; i++) begin
      eb = (cyc < e_done_cyc);
      chk("busy", {63'd0, busy_o}, {63'd0, eb});
      chk("stall", {63'd0, stall_o}, {63'd0, eb});
      if (!eb) begin
        acc = 1;
        if (op <= 3'd5) begin
          e.val = model(op, rs, rt);
          e.t0  = cyc;
          e.lat = (op >= 3'd4) ? 1 : (op >= 3'd2) ? 34 : MUL_LAT;
          {m_hi, m_lo} = e.val;
          if (op < 3'd4) e_done_cyc = cyc + e.lat;
          sb.push_back(e);
        end
      end
      @(negedge clk);
    end
    if (!acc) chk("accept_timeout", {63'd0, busy_o}, 64'd0);
    start_i = 1'b0; read_hilo_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 80; i++) begin
      if (sb.size() == 0 && cyc >= e_done_cyc) break;
      @(negedge clk); #1;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done_o) begin
      if (sb.size() == 0) chk("spurious_done", {63'd0, done_o}, 64'd0);
      else begin
        e = sb.pop_front();
        chk("hilo", {hi_o, lo_o}, e.val);
        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
        chk("busy_at_done", {63'd0, busy_o}, 64'd0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] keep_hi, keep_lo;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_hi", {32'd0, hi_o}, 64'd0);
    chk("rst_lo", {32'd0, lo_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);

    issue(3'd4, 32'h1234_5678, 32'd0, 1'b0);
    issue(3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0);
    drain();
    chk("mt_hi", {32'd0, hi_o}, 64'h1234_5678);
    chk("mt_lo", {32'd0, lo_o}, 64'h9ABC_DEF0);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(3'd3, 32'hFFFF_FFFF, 32'h10, 1'b0);
    issue(3'd3, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(3'd2, 32'h8000_0005, 32'd0, 1'b0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    issue(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    issue(3'd2, 32'd100, 32'hFFFF_FFF9, 1'b0);
    drain();

    keep_hi = hi_o;
    keep_lo = lo_o;
    issue(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
    issue(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0);
    repeat (3) @(negedge clk);
    chk("ign_hi", {32'd0, hi_o}, {32'd0, keep_hi});
    chk("ign_lo", {32'd0, lo_o}, {32'd0, keep_lo});

    for (int i = 0; i < 6; i++) begin
      issue(3'($urandom_range(0, 3)), $urandom, (i == 3) ? 32'd0 : $urandom, 1'b0);
    end
    drain();

    issue(3'd2, 32'd1000, 32'd7, 1'b1);
    issue(3'd3, 32'd12345, 32'd100, 1'b1);
    issue(3'd5, 32'h0BAD_F00D, 32'd0, 1'b1);
    drain();

    issue(3'd2, 32'd500, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    e_done_cyc = 0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", {63'd0, busy_o}, 64'd0);
    chk("midrst_hi", {32'd0, hi_o}, 64'd0);
    chk("midrst_lo", {32'd0, lo_o}, 64'd0);
    chk("midrst_done", {63'd0, done_o}, 64'd0);
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd7, 32'hFFFF_FFFB, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
